// File: rtl/pwm_iir_filter.sv
// Multi-channel first/second-order IIR low-pass for PWM bitstreams: y += (x - y) >>> k.
// One shared update datapath is walked across channels by an FSM on every sample strobe.
module pwm_iir_filter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          pwm_i,
    input  logic                       sample_i,
    input  logic [SHIFT_W-1:0]         shift_i,
    input  logic                       order2_i,
    input  logic                       clr_i,
    input  logic                       clr_ovr_i,
    output logic                       busy_o,
    output logic                       valid_o,
    output logic [NUM_CH*DATA_W-1:0]   out_o,
    output logic                       overrun_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DATA_W-1:0] FULL = '1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, S1, S2, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CH_W-1:0]                 ch_q;
    logic [NUM_CH-1:0]               pwm_q;
    logic [SHIFT_W-1:0]              shift_q;
    logic                            order2_q;
    logic [NUM_CH-1:0][DATA_W-1:0]   st1_q, st2_q, out_q;
    logic                            valid_q, overrun_q;

    logic                            last_ch;
    logic [DATA_W-1:0]               x_mux, y_mux, y_new;
    logic signed [DATA_W:0]          diff, step, sum;

    assign last_ch   = (ch_q == LAST_CH);
    assign busy_o    = (state_q != IDLE);
    assign valid_o   = valid_q;
    assign out_o     = out_q;
    assign overrun_o = overrun_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (sample_i) state_d = S1;
            S1:   if (last_ch) state_d = order2_q ? S2 : DONE;
            S2:   if (last_ch) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Stage 1 sees the PWM bit as 0/FULL; stage 2 is fed by stage 1 of the same pass.
    // The arithmetic shift floors, so the sum never leaves [0, FULL].
    always_comb begin
        x_mux = (state_q == S1) ? (pwm_q[ch_q] ? FULL : '0) : st1_q[ch_q];
        y_mux = (state_q == S1) ? st1_q[ch_q] : st2_q[ch_q];
        diff  = $signed({1'b0, x_mux}) - $signed({1'b0, y_mux});
        step  = diff >>> shift_q;
        sum   = $signed({1'b0, y_mux}) + step;
        y_new = sum[DATA_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_q     <= '0;
            pwm_q    <= '0;
            shift_q  <= '0;
            order2_q <= 1'b0;
            st1_q    <= '0;
            st2_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else if (clr_i) begin
            ch_q    <= '0;
            st1_q   <= '0;
            st2_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (sample_i) begin
                    pwm_q    <= pwm_i;
                    shift_q  <= shift_i;
                    order2_q <= order2_i;
                    ch_q     <= '0;
                end
                S1: begin
                    st1_q[ch_q] <= y_new;
                    ch_q        <= last_ch ? '0 : ch_q + 1'b1;
                end
                S2: begin
                    st2_q[ch_q] <= y_new;
                    ch_q        <= last_ch ? '0 : ch_q + 1'b1;
                end
                DONE: begin
                    out_q   <= order2_q ? st2_q : st1_q;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Set outranks clear so an overrun arriving with clr_ovr_i is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                overrun_q <= 1'b0;
        else if (sample_i && busy_o) overrun_q <= 1'b1;
        else if (clr_ovr_i)         overrun_q <= 1'b0;
    end
endmodule

// File: doc/pwm_iir_filter.md
Name: pwm_iir_filter

Overview:
- Synthesizable, multi-channel, fixed-point first/second-order IIR low-pass filter for PWM bitstreams.
- Each channel computes y += (x - y) >>> k, where x is 0 or full-scale.
- One shared datapath is time-multiplexed across channels by an FSM on each sample strobe.
- Sits after the PWM ramp generators; gives verification and on-chip monitors a registered digital estimate of each averaged PWM level.

Parameters:
- NUM_CH, 4: number of independent PWM channels (>=1).
- DATA_W, 16: filter state/output width, unsigned; full-scale FULL = 2^DATA_W-1.
- SHIFT_W, 4: width of the runtime coefficient shift k.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- pwm_i  in  NUM_CH  PWM input bit per channel.
- sample_i  in  1  single-cycle strobe requesting one filter update of all channels.
- shift_i  in  SHIFT_W  coefficient k, alpha = 2^-k; k=0 means bypass.
- order2_i  in  1  0 = first order, 1 = two cascaded stages.
- clr_i  in  1  synchronous clear of all filter state and outputs.
- clr_ovr_i  in  1  clears overrun_o.
- busy_o  out  1  high while the FSM is processing.
- valid_o  out  1  one-cycle pulse when out_o has been updated.
- out_o  out  NUM_CH*DATA_W  filtered value per channel, channel c at bits [c*DATA_W +: DATA_W].
- overrun_o  out  1  sticky: a sample_i arrived while busy.

Behaviour:
- Reset (async, rst_ni=0): all stage-1/stage-2 state, out_o, busy_o, valid_o and overrun_o are 0; FSM goes to IDLE. Reset mid-operation aborts the pass; no valid_o follows.
- FSM states:
  - IDLE -> S1 on sample_i.
  - S1 processes channels 0..NUM_CH-1, one per cycle. At the last channel: -> S2 if the latched order2 is set, else -> DONE.
  - S2 processes channels 0..NUM_CH-1 the same way, then -> DONE.
  - DONE: out_o is copied from the final-stage state, valid_o=1 for this cycle, -> IDLE.
- Accept cycle: pwm_i, shift_i and order2_i are latched when sample_i is accepted. Input changes during a pass have no effect.
- Latency: if sample_i is high at edge T, valid_o is high in the cycle after edge T+NUM_CH+1 (first order) or T+2*NUM_CH+1 (second order).
- busy_o is high from edge T until the DONE cycle inclusive.
- out_o changes only in DONE, atomically for all channels; it holds its value otherwise.
- Arithmetic per update:
  - d = signed(x) - signed(y), DATA_W+1 bits; y_new = y + (d >>> k), arithmetic shift (floors toward -inf).
  - Stage 1: x = pwm ? FULL : 0. Stage 2: x = the stage-1 result of the same pass.
  - Result is always within [0, FULL]; no saturation logic is needed.
  - k=0: y_new = x (bypass).
  - k >= DATA_W: shift result is 0 for d>=0 and -1 for d<0.
- Steady state: a constant 1 settles at FULL-(2^k-1) because of floor truncation. A constant 0 settles at exactly 0.
- sample_i while busy_o=1 (including the DONE cycle): the request is dropped and overrun_o is set. overrun_o holds until clr_ovr_i. If set and clear occur in the same cycle, set wins.
- clr_i: zeroes state and out_o and returns the FSM to IDLE next cycle with no valid_o. clr_i has priority over sample_i in the same cycle.

Test Plan:
- Reset then idle, sample_i never high -> out_o=0, busy_o=0, valid_o never pulses; assert rst_ni mid-pass -> all outputs 0 immediately and no valid_o.
- DATA_W=16, NUM_CH=4, k=3, order2=0, pwm_i=4'b0001, two samples -> ch0 = 8191 then 15359; ch1..3 = 0; valid_o exactly 5 cycles after each accepted strobe.
- Same config with order2=1, one sample -> ch0 = 1023 (stage1 8191, stage2 8191>>>3); valid_o at 9 cycles.
- k=3, pwm constant 1 for 200 samples -> ch0 = 65528; then pwm 0 for 200 samples -> ch0 = 0; k=0 -> out tracks pwm exactly (65535/0) after each sample.
- sample_i pulsed 2 cycles after an accepted strobe -> request ignored, overrun_o=1 and stays 1; clr_ovr_i pulse -> overrun_o=0; clr_ovr_i together with a new overrun -> overrun_o=1.
- clr_i during S1 -> busy_o=0 next cycle, out_o=0, no valid_o; clr_i and sample_i in the same cycle -> clear only, FSM in IDLE.
